// File: rtl/s_swap_requester.sv
// rtl/s_swap_requester.sv - RC4 S[i]/S[j] swap as four handler transactions (read i, read j, write i, write j)
// Optional: `define SWAP_SAME_ADDR_SKIP_EN to skip both writes when the latched i equals j.
module s_swap_requester #(
  parameter int N      = 17,
  parameter int M      = 8,
  parameter int ADDR_W = 8
) (
  input  logic              sm_clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [ADDR_W-1:0] addr_j,
  output logic              busy,
  output logic              done,
  output logic [M-1:0]      data_i_out,
  output logic [M-1:0]      data_j_out,
  output logic              start_request,
  output logic [N-1:0]      request_arguments,
  input  logic              reset_start_request,
  input  logic              finish,
  input  logic [M-1:0]      received_data
);

  typedef enum logic [3:0] {
    IDLE, REQ_RI, WT_RI, REQ_RJ, WT_RJ, REQ_WI, WT_WI, REQ_WJ, WT_WJ, DONE
  } state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] addr_i_q, addr_i_q_n;
  logic [ADDR_W-1:0] addr_j_q, addr_j_q_n;
  logic              busy_n, done_n, start_request_n;
  logic [N-1:0]      request_arguments_n;
  logic [M-1:0]      data_i_n, data_j_n;
  logic              xact_done;
  logic              skip_writes;

  function automatic logic [N-1:0] pack_req(input logic wren, input logic [ADDR_W-1:0] addr,
                                             input logic [M-1:0] wdata);
    return {wren, addr, wdata};
  endfunction

`ifdef SWAP_SAME_ADDR_SKIP_EN
  assign skip_writes = (addr_i_q == addr_j_q);
`else
  assign skip_writes = 1'b0;
`endif

  always_ff @(posedge sm_clk or negedge reset_n) begin
    if (!reset_n) begin
      state             <= IDLE;
      addr_i_q          <= '0;
      addr_j_q          <= '0;
      busy              <= 1'b0;
      done              <= 1'b0;
      start_request     <= 1'b0;
      request_arguments <= '0;
      data_i_out        <= '0;
      data_j_out        <= '0;
    end else begin
      state             <= state_n;
      addr_i_q          <= addr_i_q_n;
      addr_j_q          <= addr_j_q_n;
      busy              <= busy_n;
      done              <= done_n;
      start_request     <= start_request_n;
      request_arguments <= request_arguments_n;
      data_i_out        <= data_i_n;
      data_j_out        <= data_j_n;
    end
  end

  always_comb begin
    state_n             = state;
    addr_i_q_n          = addr_i_q;
    addr_j_q_n          = addr_j_q;
    busy_n              = busy;
    done_n              = 1'b0;
    start_request_n     = start_request;
    request_arguments_n = request_arguments;
    data_i_n            = data_i_out;
    data_j_n            = data_j_out;
    xact_done           = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          state_n             = REQ_RI;
          addr_i_q_n          = addr_i;
          addr_j_q_n          = addr_j;
          busy_n              = 1'b1;
          start_request_n     = 1'b1;
          request_arguments_n = pack_req(1'b0, addr_i, '0);
        end
      end
      REQ_RI, REQ_RJ, REQ_WI, REQ_WJ: begin
        if (reset_start_request) begin
          start_request_n = 1'b0;
          if (finish) begin
            xact_done = 1'b1;
          end else begin
            case (state)
              REQ_RI:  state_n = WT_RI;
              REQ_RJ:  state_n = WT_RJ;
              REQ_WI:  state_n = WT_WI;
              default: state_n = WT_WJ;
            endcase
          end
        end
      end
      WT_RI, WT_RJ, WT_WI, WT_WJ: begin
        xact_done = finish;
      end
      DONE: begin
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    // Completion of the current transaction: capture read data and launch the next request.
    if (xact_done) begin
      case (state)
        REQ_RI, WT_RI: begin
          data_i_n            = received_data;
          state_n             = REQ_RJ;
          start_request_n     = 1'b1;
          request_arguments_n = pack_req(1'b0, addr_j_q, '0);
        end
        REQ_RJ, WT_RJ: begin
          data_j_n = received_data;
          if (skip_writes) begin
            state_n = DONE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end else begin
            state_n             = REQ_WI;
            start_request_n     = 1'b1;
            request_arguments_n = pack_req(1'b1, addr_i_q, received_data);
          end
        end
        REQ_WI, WT_WI: begin
          state_n             = REQ_WJ;
          start_request_n     = 1'b1;
          request_arguments_n = pack_req(1'b1, addr_j_q, data_i_out);
        end
        default: begin
          state_n = DONE;
          busy_n  = 1'b0;
          done_n  = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_s_swap_requester.sv
// tb/tb_s_swap_requester.sv - scoreboard bench for s_swap_requester against a handler/memory model
module tb_s_swap_requester;
  localparam int N = 17;
  localparam int M = 8;
  localparam int ADDR_W = 8;

  logic              sm_clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] addr_i = '0;
  logic [ADDR_W-1:0] addr_j = '0;
  logic              busy, done, start_request;
  logic [M-1:0]      data_i_out, data_j_out;
  logic [N-1:0]      request_arguments;
  logic              reset_start_request = 1'b0;
  logic              finish = 1'b0;
  logic [M-1:0]      received_data = '0;

  s_swap_requester #(.N(N), .M(M), .ADDR_W(ADDR_W)) dut (
    .sm_clk(sm_clk), .reset_n(reset_n), .start(start), .addr_i(addr_i), .addr_j(addr_j),
    .busy(busy), .done(done), .data_i_out(data_i_out), .data_j_out(data_j_out),
    .start_request(start_request), .request_arguments(request_arguments),
    .reset_start_request(reset_start_request), .finish(finish), .received_data(received_data)
  );

  always #5 sm_clk = ~sm_clk;

  int checks = 0;
  int failures = 0;
  logic [M-1:0] mem [256];
  logic [N-1:0] exp_q[$];
  logic [N-1:0] obs_q[$];
  logic [M-1:0] rd_force_q[$];
  bit           same_cycle = 1'b0;
  int           h_st = 0;
  int           h_cnt = 0;
  logic [N-1:0] h_args = '0;
  logic [M-1:0] h_rdata = '0;
  int           stab_err = 0;
  int           done_cnt = 0;
  int           gap_cnt = 0;

  // Handler model: ack one cycle after a request, finish three cycles after ack (or with ack in same_cycle mode).
  // Writes commit at ack; it keeps running through a requester reset like the real handler would.
  always @(negedge sm_clk) begin
    reset_start_request = 1'b0;
    finish = 1'b0;
    if (done === 1'b1) done_cnt++;
    if (busy === 1'b1 && start_request !== 1'b1) gap_cnt++;
    case (h_st)
      0: if (start_request === 1'b1) begin
        h_args = request_arguments;
        obs_q.push_back(h_args);
        h_cnt = 1;
        h_st = 1;
      end
      1: begin
        if (request_arguments !== h_args) stab_err++;
        if (h_cnt > 1) h_cnt--;
        else begin
          reset_start_request = 1'b1;
          if (h_args[N-1]) begin
            mem[h_args[M +: ADDR_W]] = h_args[M-1:0];
            h_rdata = '0;
          end else if (rd_force_q.size() > 0) h_rdata = rd_force_q.pop_front();
          else h_rdata = mem[h_args[M +: ADDR_W]];
          if (same_cycle) begin
            finish = 1'b1;
            received_data = h_rdata;
            h_st = 0;
          end else begin
            h_cnt = 3;
            h_st = 2;
          end
        end
      end
      default: begin
        if (request_arguments !== h_args) stab_err++;
        if (h_cnt > 1) h_cnt--;
        else begin
          finish = 1'b1;
          received_data = h_rdata;
          h_st = 0;
        end
      end
    endcase
  end

  task automatic do_start(input logic [ADDR_W-1:0] i, input logic [ADDR_W-1:0] j);
    @(negedge sm_clk);
    addr_i = i;
    addr_j = j;
    start = 1'b1;
    @(negedge sm_clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit seen, output logic busy_at);
    seen = 1'b0;
    busy_at = 1'bx;
    for (int c = 0; c < budget && !seen; c++) begin
      @(negedge sm_clk);
      if (done === 1'b1) begin
        seen = 1'b1;
        busy_at = busy;
      end
    end
  endtask

  task automatic push_exp(input logic w, input logic [ADDR_W-1:0] a, input logic [M-1:0] d);
    exp_q.push_back({w, a, d});
  endtask

  task automatic test_reset;
    bit ok;
    reset_n = 1'b0;
    repeat (2) @(negedge sm_clk);
    checks++;
    if ({busy, done, start_request, request_arguments, data_i_out, data_j_out} !== '0) begin
      failures++;
      $display("FAIL reset_por: outputs=%h required 0",
               {busy, done, start_request, request_arguments, data_i_out, data_j_out});
    end
    reset_n = 1'b1;
    mem[8'h40] = 8'h9E;
    mem[8'h41] = 8'h21;
    do_start(8'h40, 8'h41);
    ok = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge sm_clk); #1;
      if (obs_q.size() == 2 && h_st == 2) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok || data_i_out !== 8'h9E) begin
      failures++;
      $display("FAIL reset_pre: reached_wt_rj=%0d data_i_out=%h required 1/9e", ok, data_i_out);
    end
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, start_request, request_arguments, data_i_out, data_j_out} !== '0) begin
      failures++;
      $display("FAIL reset_async: outputs=%h required 0",
               {busy, done, start_request, request_arguments, data_i_out, data_j_out});
    end
    @(negedge sm_clk);
    reset_n = 1'b1;
    repeat (10) @(negedge sm_clk);
    checks++;
    if (busy !== 1'b0 || obs_q.size() != 2) begin
      failures++;
      $display("FAIL reset_idle: busy=%b requests=%0d required 0/2", busy, obs_q.size());
    end
    obs_q.delete();
  endtask

  task automatic test_nominal;
    bit seen;
    logic busy_at;
    logic [N-1:0] e, o;
    int dc0, st0;
    mem[8'h03] = 8'hAA;
    mem[8'h10] = 8'h55;
    dc0 = done_cnt;
    st0 = stab_err;
    push_exp(1'b0, 8'h03, 8'h00);
    push_exp(1'b0, 8'h10, 8'h00);
    push_exp(1'b1, 8'h03, 8'h55);
    push_exp(1'b1, 8'h10, 8'hAA);
    do_start(8'h03, 8'h10);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL nominal_busy: busy=%b required 1", busy); end
    wait_done(300, seen, busy_at);
    checks++;
    if (!seen || busy_at !== 1'b0) begin
      failures++;
      $display("FAIL nominal_done: seen=%0d busy_at_done=%b required 1/0", seen, busy_at);
    end
    checks++;
    if (data_i_out !== 8'hAA || data_j_out !== 8'h55) begin
      failures++;
      $display("FAIL nominal_data: i=%h j=%h required aa/55", data_i_out, data_j_out);
    end
    repeat (3) @(negedge sm_clk);
    checks++;
    if (done_cnt - dc0 != 1 || stab_err != st0) begin
      failures++;
      $display("FAIL nominal_pulse: done_pulses=%0d unstable_args=%0d required 1/0", done_cnt - dc0, stab_err - st0);
    end
    checks++;
    if (mem[8'h03] !== 8'h55 || mem[8'h10] !== 8'hAA) begin
      failures++;
      $display("FAIL nominal_mem: mem03=%h mem10=%h required 55/aa", mem[8'h03], mem[8'h10]);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin failures++; $display("FAIL nominal_req: got none required %h", e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin failures++; $display("FAIL nominal_req: got %h required %h", o, e); end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin failures++; $display("FAIL nominal_extra: %0d extra requests required 0", obs_q.size()); end
    obs_q.delete();
  endtask

  task automatic test_start_ignored;
    bit seen, ok;
    logic busy_at;
    logic [N-1:0] e, o;
    int dc0;
    mem[8'h05] = 8'h5A;
    mem[8'h06] = 8'hA5;
    mem[8'h20] = 8'h77;
    dc0 = done_cnt;
    push_exp(1'b0, 8'h05, 8'h00);
    push_exp(1'b0, 8'h06, 8'h00);
    push_exp(1'b1, 8'h05, 8'hA5);
    push_exp(1'b1, 8'h06, 8'h5A);
    do_start(8'h05, 8'h06);
    ok = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge sm_clk); #1;
      if (obs_q.size() == 2 && h_st == 2) begin ok = 1'b1; break; end
    end
    addr_i = 8'h20;
    addr_j = 8'h20;
    start = 1'b1;
    @(negedge sm_clk);
    start = 1'b0;
    wait_done(300, seen, busy_at);
    repeat (5) @(negedge sm_clk);
    checks++;
    if (!ok || !seen || done_cnt - dc0 != 1) begin
      failures++;
      $display("FAIL ignore_done: in_wt_rj=%0d seen=%0d pulses=%0d required 1/1/1", ok, seen, done_cnt - dc0);
    end
    checks++;
    if (mem[8'h05] !== 8'hA5 || mem[8'h06] !== 8'h5A || mem[8'h20] !== 8'h77) begin
      failures++;
      $display("FAIL ignore_mem: mem05=%h mem06=%h mem20=%h required a5/5a/77", mem[8'h05], mem[8'h06], mem[8'h20]);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin failures++; $display("FAIL ignore_req: got none required %h", e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin failures++; $display("FAIL ignore_req: got %h required %h", o, e); end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin failures++; $display("FAIL ignore_extra: %0d extra requests required 0", obs_q.size()); end
    obs_q.delete();
  endtask

  task automatic test_back_to_back;
    bit seen;
    logic busy_at;
    logic [N-1:0] e, o;
    int g0, dc0;
    same_cycle = 1'b1;
    rd_force_q.push_back(8'h11);
    rd_force_q.push_back(8'h22);
    g0 = gap_cnt;
    dc0 = done_cnt;
    push_exp(1'b0, 8'h50, 8'h00);
    push_exp(1'b0, 8'h51, 8'h00);
    push_exp(1'b1, 8'h50, 8'h22);
    push_exp(1'b1, 8'h51, 8'h11);
    do_start(8'h50, 8'h51);
    wait_done(100, seen, busy_at);
    repeat (3) @(negedge sm_clk);
    same_cycle = 1'b0;
    checks++;
    if (!seen || done_cnt - dc0 != 1 || gap_cnt != g0) begin
      failures++;
      $display("FAIL b2b_flow: seen=%0d pulses=%0d wait_cycles=%0d required 1/1/0", seen, done_cnt - dc0, gap_cnt - g0);
    end
    checks++;
    if (data_i_out !== 8'h11 || data_j_out !== 8'h22) begin
      failures++;
      $display("FAIL b2b_data: i=%h j=%h required 11/22", data_i_out, data_j_out);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin failures++; $display("FAIL b2b_req: got none required %h", e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin failures++; $display("FAIL b2b_req: got %h required %h", o, e); end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin failures++; $display("FAIL b2b_extra: %0d extra requests required 0", obs_q.size()); end
    obs_q.delete();
  endtask

  task automatic test_reset_wt_wi;
    bit ok;
    logic [N-1:0] e, o;
    mem[8'h30] = 8'h12;
    mem[8'h31] = 8'h34;
    push_exp(1'b0, 8'h30, 8'h00);
    push_exp(1'b0, 8'h31, 8'h00);
    push_exp(1'b1, 8'h30, 8'h34);
    do_start(8'h30, 8'h31);
    ok = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge sm_clk); #1;
      if (obs_q.size() == 3 && h_st == 2) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok || busy !== 1'b1) begin
      failures++;
      $display("FAIL wtwi_reach: in_wt_wi=%0d busy=%b required 1/1", ok, busy);
    end
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if (start_request !== 1'b0 || busy !== 1'b0 || request_arguments !== '0) begin
      failures++;
      $display("FAIL wtwi_async: start_request=%b busy=%b args=%h required 0/0/0", start_request, busy, request_arguments);
    end
    @(negedge sm_clk);
    reset_n = 1'b1;
    repeat (30) @(negedge sm_clk);
    checks++;
    if (mem[8'h30] !== 8'h34 || mem[8'h31] !== 8'h34) begin
      failures++;
      $display("FAIL wtwi_mem: mem30=%h mem31=%h required 34/34", mem[8'h30], mem[8'h31]);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin failures++; $display("FAIL wtwi_req: got none required %h", e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin failures++; $display("FAIL wtwi_req: got %h required %h", o, e); end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin failures++; $display("FAIL wtwi_extra: %0d extra requests required 0", obs_q.size()); end
    obs_q.delete();
  endtask

  task automatic test_same_addr;
    bit seen;
    logic busy_at;
    logic [N-1:0] e, o;
    mem[8'h07] = 8'h3C;
    push_exp(1'b0, 8'h07, 8'h00);
    push_exp(1'b0, 8'h07, 8'h00);
`ifndef SWAP_SAME_ADDR_SKIP_EN
    push_exp(1'b1, 8'h07, 8'h3C);
    push_exp(1'b1, 8'h07, 8'h3C);
`endif
    do_start(8'h07, 8'h07);
    wait_done(300, seen, busy_at);
    repeat (5) @(negedge sm_clk);
    checks++;
    if (!seen || data_i_out !== 8'h3C || data_j_out !== 8'h3C || mem[8'h07] !== 8'h3C) begin
      failures++;
      $display("FAIL same_data: seen=%0d i=%h j=%h mem07=%h required 1/3c/3c/3c", seen, data_i_out, data_j_out, mem[8'h07]);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin failures++; $display("FAIL same_req: got none required %h", e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin failures++; $display("FAIL same_req: got %h required %h", o, e); end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin failures++; $display("FAIL same_extra: %0d extra requests required 0", obs_q.size()); end
    obs_q.delete();
  endtask

  initial begin
    for (int k = 0; k < 256; k++) mem[k] = k[7:0] ^ 8'hC3;
    test_reset();
    test_nominal();
    test_start_ignored();
    test_back_to_back();
    test_reset_wt_wi();
    test_same_addr();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
